// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO between the UART receiver and the host, with sticky overflow flag.
// Define UART_RX_FIFO_ERR_STATS_EN to add saturating per-error-bit counters.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned WIDTH  = 12
) (
    input  logic              UART_clk,
    input  logic              rst_n,
    input  logic              wr_tick,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              rx_stop,
    output logic              ovf,
    input  logic              ovf_clr
`ifdef UART_RX_FIFO_ERR_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [7:0]        fe_cnt,
    output logic [7:0]        pe_cnt,
    output logic [7:0]        oe_cnt,
    output logic [7:0]        be_cnt
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;

    // Extra pointer MSB distinguishes a full buffer from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rx_stop = full;

    // A full buffer is never empty, so a same-cycle pop always frees the slot.
    assign pop  = rd_en && !empty;
    assign push = wr_tick && (!full || rd_en);
    assign drop = wr_tick && full && !rd_en;

    // NOTE: the storage array has no reset; its contents are don't-care until written,
    // and leaving it out of the reset lets it map onto plain RAM.
    always_ff @(posedge UART_clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // NOTE: all state uses non-blocking assignments, so a read of the slot being
    // refilled in the same cycle returns the old word.
    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_ERR_STATS_EN
    // Index 0..3 follows wr_data bits 8..11: FE, PE, OE, BE.
    logic [7:0] err_cnt [4];

    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                err_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (stats_clr) begin
                    err_cnt[i] <= 8'd0;
                end else if (push && wr_data[8+i] && (err_cnt[i] != 8'hFF)) begin
                    err_cnt[i] <= err_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign fe_cnt = err_cnt[0];
    assign pe_cnt = err_cnt[1];
    assign oe_cnt = err_cnt[2];
    assign be_cnt = err_cnt[3];
`endif

endmodule
